sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: HALF_CYCLES, default 2, cycles each 16-bit half-access holds the bus (legal 1..15).
REQ-002 Parameter: BASE_ADDR, default 32'd1024, byte address mapped to SRAM halfword 0.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, resets on assertion without waiting for clk.
REQ-004 Request ports SHALL be: wr_en input 1, MEM-stage write request; rd_en input 1, MEM-stage read request.
REQ-005 Data ports SHALL be: address input 32, byte address, word-aligned; write_data input 32, store data.
REQ-006 Result ports SHALL be: read_data output 32, load data; ready output 1, access complete or idle (pipeline freeze = !ready).
REQ-007 SRAM ports SHALL be: sram_addr output 18, halfword address; sram_dq_out output 16; sram_dq_in input 16; sram_dq_oe output 1, drive enable; sram_we_n output 1, active-low write strobe.

Function
REQ-008 The FSM SHALL have states IDLE, ACC_LO, ACC_HI and DONE.
REQ-009 In IDLE with wr_en or rd_en high, the block SHALL latch address, write_data and the operation type, then enter ACC_LO next cycle.
REQ-010 When wr_en and rd_en are both high, the block SHALL perform a write and ignore the read.
REQ-011 ACC_LO and ACC_HI SHALL each last exactly HALF_CYCLES cycles, timed by a down-counter, and DONE SHALL last 1 cycle before returning to IDLE.
REQ-012 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
REQ-013 Read latency (request in IDLE to ready high) SHALL be 2*HALF_CYCLES+1 cycles.
REQ-014 Address mapping: eff = address - BASE_ADDR, truncated to 19 bits; sram_addr = {eff[18:2], 0} in ACC_LO and {eff[18:2], 1} in ACC_HI.
REQ-015 On a write, sram_dq_out SHALL carry write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI.
REQ-016 On a write, sram_dq_oe SHALL be 1 throughout the access, and sram_we_n SHALL be 0 on every ACC cycle except the last cycle of each half.
REQ-017 On a read, sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1.
REQ-018 On a read, the last ACC_LO cycle SHALL capture sram_dq_in into read_data[15:0], and the last ACC_HI cycle SHALL capture it into read_data[31:16].
REQ-019 read_data SHALL hold its value until the next read's capture.
REQ-020 Request inputs SHALL be ignored outside IDLE; a request held high through DONE SHALL start a new access on the following IDLE cycle.
REQ-021 An address below BASE_ADDR SHALL wrap modulo 2^19 with no error flag.

Reset
REQ-022 On rst, the block SHALL enter IDLE and clear the counter and latches; outputs SHALL be read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, and ready=1.
REQ-023 Reset asserted mid-access SHALL abort the access and raise sram_we_n within the same cycle; a half-written word is not repaired.

Configuration
REQ-024 With SRAM_CTRL_POSTED_WRITE_EN defined, a write accepted in IDLE SHALL assert ready in the acceptance cycle and complete in the background.
REQ-025 With SRAM_CTRL_POSTED_WRITE_EN defined, ready SHALL be 0 for any request arriving while the background write is busy, and that request SHALL be serviced from IDLE afterwards.
REQ-026 With SRAM_CTRL_POSTED_WRITE_EN undefined, writes SHALL be blocking with latency 2*HALF_CYCLES+1, identical to reads.

Structure
REQ-027 The shared package arm_pkg SHALL hold the sram_state_t enum, SRAM_ADDR_W=18, SRAM_DATA_W=16 and the BASE_ADDR default.
REQ-028 The block SHALL contain one sub-module, sram_wait_cnt: a loadable down-counter with a zero flag, used for half-access timing.

Verification
REQ-029 With HALF_CYCLES=2, a write to address 1024 with data 0xDEADBEEF SHALL drive sram_addr 0 with 0xBEEF, then sram_addr 1 with 0xDEAD, and ready SHALL be high 5 cycles after the request.
REQ-030 A read of address 1032 with SRAM halfword 4=0x5678 and halfword 5=0x1234 SHALL return read_data=0x12345678 with ready high 5 cycles after the request.
REQ-031 wr_en and rd_en both high at address 1028 SHALL perform only a write, and sram_dq_oe SHALL be 1 throughout.
REQ-032 rst asserted in cycle 2 of ACC_HI during a write SHALL give sram_we_n=1, state IDLE, ready=1 and read_data=0 immediately, with no further SRAM strobes.
REQ-033 With SRAM_CTRL_POSTED_WRITE_EN defined, a write then a back-to-back read SHALL give ready=1 in the write cycle, ready=0 for 5 cycles, then the read result 5 cycles later.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared SRAM controller types, bus widths and default base address.
package arm_pkg;
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} sram_state_t;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter with zero flag, times each half-access.
module sram_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (!zero) cnt_q <= cnt_q - 1'b1;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit MEM-stage access split into two 16-bit SRAM halves.
// SRAM_CTRL_POSTED_WRITE_EN: writes release ready on acceptance and finish in the background.
module sram_controller import arm_pkg::*; #(
  parameter int          HALF_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  sram_state_t state_q;
  logic wr_q;
  logic [SRAM_ADDR_W-2:0] hw_q;
  logic [31:0] wdata_q, rdata_q, eff;
  logic req, acc, zero, load, unused_eff;
  assign req = wr_en | rd_en;
  assign eff = address - BASE_ADDR;
  assign unused_eff = ^{eff[31:19], eff[1:0]};
  assign acc = state_q == ACC_LO || state_q == ACC_HI;
  assign load = (state_q == IDLE && req) || (state_q == ACC_LO && zero);
  sram_wait_cnt #(.W(4)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (4'(HALF_CYCLES - 1)),
    .zero     (zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      hw_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q <= ACC_LO;
          wr_q    <= wr_en;
          hw_q    <= eff[18:2];
          wdata_q <= write_data;
        end
        ACC_LO: if (zero) begin
          state_q <= ACC_HI;
          if (!wr_q) rdata_q[15:0] <= sram_dq_in;
        end
        ACC_HI: if (zero) begin
          state_q <= DONE;
          if (!wr_q) rdata_q[31:16] <= sram_dq_in;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign sram_addr   = acc ? {hw_q, state_q == ACC_HI} : '0;
  assign sram_dq_out = acc && wr_q ? (state_q == ACC_HI ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign sram_dq_oe  = acc && wr_q;
  // Strobe drops on the final cycle of each half so data/address are stable at its rising edge.
  assign sram_we_n   = !(acc && wr_q && !zero);
  assign read_data   = rdata_q;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
  assign ready = state_q == IDLE ? (wr_en || !rd_en) : (state_q == DONE && !wr_q) || (wr_q && !req);
`else
  assign ready = (state_q == IDLE && !req) || state_q == DONE;
`endif
endmodule
